// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
package serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin.
// Purely combinational; the borrow is held by the parent.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Result and final borrow are registered and held until the next DONE.
module serial_subtractor
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             fs_d;
    logic             fs_bout;
    logic [WIDTH-1:0] res_next;

    full_subtractor u_fs (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .bin  (br_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    assign res_next = {fs_d, res_q[WIDTH-1:1]};

    // Next-state and datapath: load, shift one bit, publish result.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        br_d     = br_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_next;
                br_d  = fs_bout;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d   = res_next;
                    borrow_d = fs_bout;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8.
// Stimulus pushes expected results; a forked monitor pops on done.
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         borrow;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    exp_t         exp_q[$];
    int           checks;
    int           errors;
    int           done_cnt;
    int           pushed;
    logic [W-1:0] last_diff;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    function automatic void push(logic [W-1:0] d, logic br);
        exp_t e;
        e.diff   = d;
        e.borrow = br;
        exp_q.push_back(e);
        pushed++;
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("diff", 32'(diff), 32'(e.diff));
                    chk("borrow_out", 32'(borrow_out), 32'(e.borrow));
                end
            end
        end
    endtask

    // Issue one op from an IDLE cycle; checks latency and result hold.
    task automatic run_op(logic [W-1:0] av, logic [W-1:0] bv,
                          logic [W-1:0] ed, logic eb);
        bit seen;
        seen  = 0;
        a     = av;
        b     = bv;
        start = 1'b1;
        push(ed, eb);
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= W + 4; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                chk("latency", 32'(k), 32'(W));
                seen = 1;
                break;
            end
            if (k < W) chk("diff_hold", 32'(diff), 32'(last_diff));
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        last_diff = ed;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t1;
        int t2;
        int cyc;
        bit seen;
        checks    = 0;
        errors    = 0;
        done_cnt  = 0;
        pushed    = 0;
        last_diff = '0;
        rst       = 1'b1;
        start     = 1'b1;
        a         = 8'h77;
        b         = 8'h11;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow_out), 32'd0);
        rst = 1'b0;

        run_op(8'h05, 8'h03, 8'h02, 1'b0);
        run_op(8'h03, 8'h05, 8'hFE, 1'b1);
        run_op(8'h00, 8'h01, 8'hFF, 1'b1);
        run_op(8'hFF, 8'hFF, 8'h00, 1'b0);
        run_op(8'hFF, 8'h00, 8'hFF, 1'b0);
        run_op(8'h00, 8'h00, 8'h00, 1'b0);
        run_op(8'h80, 8'h01, 8'h7F, 1'b0);
        run_op(8'h01, 8'h80, 8'h81, 1'b1);
        run_op(8'hAA, 8'h55, 8'h55, 1'b0);
        run_op(8'h55, 8'hAA, 8'hAB, 1'b1);

        // Second start during SHIFT must be ignored.
        a     = 8'hA5;
        b     = 8'h5A;
        start = 1'b1;
        push(8'h4B, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        a     = 8'h11;
        b     = 8'h22;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 0;
        for (int k = 0; k < 3 * W; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk("ignore_timeout", 32'd0, 32'd1);
        repeat (2 * W) @(posedge clk);
        #1;
        chk("ignore_idle", 32'(busy), 32'd0);
        chk("ignore_diff", 32'(diff), 32'h4B);
        last_diff = 8'h4B;

        // Reset in the middle of SHIFT aborts without a done pulse.
        a     = 8'h33;
        b     = 8'h11;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_borrow", 32'(borrow_out), 32'd0);
        rst       = 1'b0;
        last_diff = '0;
        run_op(8'h40, 8'h0F, 8'h31, 1'b0);

        // start held high: back-to-back ops every W+2 cycles.
        a     = 8'h10;
        b     = 8'h01;
        start = 1'b1;
        push(8'h0F, 1'b0);
        push(8'h0F, 1'b0);
        t1 = -1;
        t2 = -1;
        cyc = 0;
        for (int k = 0; k < 3 * (W + 2); k++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done === 1'b1) begin
                if (t1 < 0) t1 = cyc;
                else if (t2 < 0) t2 = cyc;
            end
            if (t2 >= 0) begin
                start = 1'b0;
                break;
            end
        end
        start = 1'b0;
        chk("held_gap", 32'(t2 - t1), 32'(W + 2));
        chk("held_first", 32'(t1), 32'(W + 1));
        repeat (W + 4) @(posedge clk);
        #1;
        last_diff = diff;

        // Strided sweep against an arithmetic reference.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 20; j++) begin
                logic [W-1:0] av;
                logic [W-1:0] bv;
                av = W'(i * 17);
                bv = W'(j * 13);
                run_op(av, bv, av - bv, av < bv);
            end
        end

        cyc = 0;
        while (exp_q.size() != 0 && cyc < 4 * W) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("done_count", 32'(done_cnt), 32'(pushed));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
